scurve_sweep_ctrl: RTL and testbench
====================================

# scurve_sweep_ctrl

Sequencer one level above the single-channel S-curve tester. Walks a channel range (outer loop) and a threshold-DAC range (inner loop). For each point it:
- requests an ASIC slow-control reload,
- waits for the load to finish, then waits a fixed settle time,
- writes one header word to the readout FIFO,
- pulses the single-channel test start and forwards that tester's 16-bit data words to the same FIFO.

After the last point it writes a trailer word and reports done.

## Interface
Parameters:
- `CHN_WIDTH`, 6: channel index width (64 channels).
- `DAC_WIDTH`, 10: threshold DAC code width; `CHN_WIDTH + DAC_WIDTH` must equal 16.
- `SETTLE_CYCLES`, 1000: wait in `Clk` cycles between `Config_Done` and the header write; minimum 1.

Ports:
- `Clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `Sweep_Start` in 1: one-cycle pulse; ignored unless in IDLE.
- `Sweep_Stop` in 1: one-cycle pulse; requests a graceful abort.
- `Start_Chn`, `End_Chn` in `CHN_WIDTH`: inclusive channel range; sampled on `Sweep_Start`.
- `Start_DAC`, `End_DAC` in `DAC_WIDTH`: inclusive DAC range; sampled on `Sweep_Start`.
- `DAC_Step` in `DAC_WIDTH`: DAC increment; sampled on `Sweep_Start`; 0 is treated as 1.
- `Cfg_Chn` out `CHN_WIDTH`: channel to unmask.
- `Cfg_DAC` out `DAC_WIDTH`: threshold code to load.
- `Config_Load` out 1: one-cycle pulse to the slow-control block.
- `Config_Done` in 1: pulse from slow control when the load is complete.
- `SCurve_Test_Start` out 1: one-cycle pulse to the single-channel tester.
- `One_Channel_Done` in 1: tester finished; may be high for more than one cycle.
- `SCurve_Data` in 16: tester data word.
- `SCurve_Data_wr_en` in 1: tester data strobe.
- `Fifo_Data` out 16: merged stream to the readout FIFO.
- `Fifo_wr_en` out 1: FIFO write strobe.
- `Sweep_Busy` out 1: high from the cycle after an accepted start until DONE.
- `Sweep_Done` out 1: one-cycle pulse at the end of a sweep.

## Operation
States: IDLE, LOAD_CFG, WAIT_CFG, SETTLE, HEADER, TEST, WAIT_DONE, NEXT, TRAILER, DONE.

- **IDLE**: on `Sweep_Start`:
  - latch the ranges;
  - chn ← `Start_Chn`, dac ← `Start_DAC`;
  - clear the stop flag;
  - go to LOAD_CFG.
- **LOAD_CFG**: drive `Cfg_Chn`/`Cfg_DAC` from the current point; pulse `Config_Load`; go to WAIT_CFG.
- **WAIT_CFG**: wait for `Config_Done`; on it, load the settle counter with `SETTLE_CYCLES-1` and go to SETTLE.
- **SETTLE**: count down to 0, then go to HEADER.
- **HEADER**: write `Fifo_Data = {chn, dac}` with `Fifo_wr_en` = 1; go to TEST.
- **TEST**: pulse `SCurve_Test_Start`; go to WAIT_DONE.
- **WAIT_DONE**:
  - every `SCurve_Data_wr_en` is copied to `Fifo_wr_en` and `SCurve_Data` to `Fifo_Data`, registered with 1-cycle latency;
  - on a rising edge of `One_Channel_Done`, go to NEXT. A level that is still high from the previous point must not retrigger, so edge detection is required.
- **NEXT**: compute `nd = dac + step` in `DAC_WIDTH+1` bits.
  - If the stop flag is set, or this was the last point, go to TRAILER.
  - Else if `nd > End_DAC`: dac ← `Start_DAC`, chn ← chn+1, go to LOAD_CFG.
  - Else: dac ← nd, go to LOAD_CFG.
  - The last point is `chn == End_Chn` with `nd > End_DAC`.
- **TRAILER**: write 16'hFFFF; go to DONE.
- **DONE**: pulse `Sweep_Done`; go to IDLE.

Rules and boundary conditions:
- `Sweep_Stop` in any non-IDLE state sets the stop flag. The current point still completes (header plus tester data), so the FIFO never holds a header without its data.
- Degenerate ranges:
  - `Start_DAC > End_DAC`: exactly one point per channel, at `Start_DAC`.
  - `Start_Chn > End_Chn`: only `Start_Chn` is swept.
- DAC overflow past all-ones is caught by the extra carry bit and treated as `nd > End_DAC`.
- `Sweep_Start` while busy is ignored; `Sweep_Stop` in IDLE is ignored.
- Header and tester data never collide: tester strobes outside WAIT_DONE are dropped.
- `reset` in any state wins. All outputs return to their reset values on the next edge and the state goes to IDLE.

## Timing
- Reset values: all outputs 0, including `Fifo_Data`, `Cfg_Chn` and `Cfg_DAC`.
- `Config_Load` comes 1 cycle after `Sweep_Start` (LOAD_CFG is entered on the following edge).
- The header write comes exactly `SETTLE_CYCLES+1` cycles after the cycle in which `Config_Done` is sampled.
- `SCurve_Test_Start` is asserted the cycle after the header write.
- Data forwarding has a fixed 1-cycle latency.
- From a rising edge of `One_Channel_Done` to the next `Config_Load` is 2 cycles (NEXT, then LOAD_CFG).
- Per point, the FIFO receives 1 header word plus whatever the tester emits (nominally 6 words).

## Structure
- Shared package `scurve_pkg`:
  - `TRAILER_WORD` = 16'hFFFF;
  - the state enum;
  - `CHN_WIDTH`/`DAC_WIDTH` defaults.
- One natural sub-module, `scurve_settle_timer`: a loadable down-counter with a zero flag. Everything else stays in one FSM module.

## Test plan
- **Single point**: chn 5..5, DAC 100..100, step 1, tester returns 6 words → FIFO gets 16'h1464, the 6 words, 16'hFFFF; one `Sweep_Done`.
- **DAC wrap**: chn 0..1, DAC 1020..1023, step 2 → headers 0x03FC, 0x03FE, 0x07FC, 0x07FE, then trailer; 4 `Config_Load` pulses.
- **Step 0**: DAC 0..2 → 3 points (step behaves as 1).
- **Stop**: `Sweep_Stop` mid-WAIT_CFG of point 2 → point 2 completes with header and data, trailer follows, no point 3.
- **Settle/latency**: `SETTLE_CYCLES`=4 → header exactly 5 cycles after `Config_Done`; `One_Channel_Done` held high for 3 cycles → only one advance.
- **Reset mid-sweep**: `reset` during WAIT_DONE → next cycle IDLE, all outputs 0; a fresh `Sweep_Start` restarts from `Start_Chn`/`Start_DAC`.

Source files
------------

// File: rtl/scurve_pkg.sv
// -----------------------------------------------------------------------------
// scurve_pkg
// Shared definitions for the S-curve sweep sequencer:
//   - default channel / threshold-DAC widths (their sum forms one 16-bit
//     header word),
//   - the trailer word that closes every sweep in the readout FIFO,
//   - the sweep sequencer state encoding.
// -----------------------------------------------------------------------------
package scurve_pkg;

    localparam int DEF_CHN_WIDTH = 6;
    localparam int DEF_DAC_WIDTH = 10;

    localparam logic [15:0] TRAILER_WORD = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CFG,
        ST_WAIT_CFG,
        ST_SETTLE,
        ST_HEADER,
        ST_TEST,
        ST_WAIT_DONE,
        ST_NEXT,
        ST_TRAILER,
        ST_DONE
    } sweep_state_t;

endpackage

// File: rtl/scurve_settle_timer.sv
// -----------------------------------------------------------------------------
// scurve_settle_timer
// Loadable down-counter used to let the ASIC thresholds settle after a
// slow-control reload. Loading a value N makes 'zero' rise N cycles later;
// loading 0 gives an immediate 'zero'.
//
// Ports:
//   Clk         system clock
//   reset       synchronous, active-high reset (counter cleared)
//   load        load 'load_value' into the counter this cycle
//   load_value  start value of the countdown
//   zero        high while the counter holds 0
// -----------------------------------------------------------------------------
module scurve_settle_timer
    import scurve_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // The counter parks at zero once it gets there; a fresh load always
    // takes priority so a reload restarts the countdown cleanly.
    always_ff @(posedge Clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/scurve_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// scurve_sweep_ctrl
// Sweep sequencer sitting above the single-channel S-curve tester. It walks
// channels (outer loop) and threshold DAC codes (inner loop). For each point
// it reloads the ASIC slow control, waits for the load plus a settle time,
// writes a {chn, dac} header into the readout FIFO, starts the tester and
// forwards the tester's data words into the same FIFO. A trailer word and a
// done pulse close the sweep.
//
// Ports:
//   Clk, reset            clock, synchronous active-high reset
//   Sweep_Start           start pulse (only honoured when idle)
//   Sweep_Stop            graceful abort request (current point completes)
//   Start_Chn, End_Chn    inclusive channel range, sampled on start
//   Start_DAC, End_DAC    inclusive DAC range, sampled on start
//   DAC_Step              DAC increment, sampled on start (0 behaves as 1)
//   Cfg_Chn, Cfg_DAC      point to load into the ASIC
//   Config_Load           slow-control reload pulse
//   Config_Done           slow-control load complete pulse
//   SCurve_Test_Start     single-channel tester start pulse
//   One_Channel_Done      tester finished (level, may stay high)
//   SCurve_Data(_wr_en)   tester data words and strobe
//   Fifo_Data, Fifo_wr_en merged header/data/trailer stream
//   Sweep_Busy            sweep in progress
//   Sweep_Done            end-of-sweep pulse
// -----------------------------------------------------------------------------
module scurve_sweep_ctrl
    import scurve_pkg::*;
#(
    parameter int CHN_WIDTH     = DEF_CHN_WIDTH,
    parameter int DAC_WIDTH     = DEF_DAC_WIDTH,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 Sweep_Start,
    input  logic                 Sweep_Stop,
    input  logic [CHN_WIDTH-1:0] Start_Chn,
    input  logic [CHN_WIDTH-1:0] End_Chn,
    input  logic [DAC_WIDTH-1:0] Start_DAC,
    input  logic [DAC_WIDTH-1:0] End_DAC,
    input  logic [DAC_WIDTH-1:0] DAC_Step,
    output logic [CHN_WIDTH-1:0] Cfg_Chn,
    output logic [DAC_WIDTH-1:0] Cfg_DAC,
    output logic                 Config_Load,
    input  logic                 Config_Done,
    output logic                 SCurve_Test_Start,
    input  logic                 One_Channel_Done,
    input  logic [15:0]          SCurve_Data,
    input  logic                 SCurve_Data_wr_en,
    output logic [15:0]          Fifo_Data,
    output logic                 Fifo_wr_en,
    output logic                 Sweep_Busy,
    output logic                 Sweep_Done
);

    localparam int TIMER_WIDTH = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TIMER_WIDTH-1:0] SETTLE_LOAD = TIMER_WIDTH'(SETTLE_CYCLES - 1);

    sweep_state_t         state;
    sweep_state_t         state_next;

    logic [CHN_WIDTH-1:0] chn;
    logic [CHN_WIDTH-1:0] end_chn;
    logic [DAC_WIDTH-1:0] dac;
    logic [DAC_WIDTH-1:0] start_dac;
    logic [DAC_WIDTH-1:0] end_dac;
    logic [DAC_WIDTH-1:0] step;
    logic                 stop_flag;
    logic                 ocd_q;
    logic [15:0]          fifo_data;
    logic                 fifo_wr_en;

    logic [DAC_WIDTH:0]   next_dac;
    logic                 dac_past_end;
    logic                 last_point;
    logic                 stop_req;
    logic                 ocd_rise;
    logic                 settle_load;
    logic                 settle_zero;

    // Next DAC code carries one extra bit so stepping past all-ones reads as
    // "beyond the end of the range" instead of silently wrapping to 0.
    // The last channel test uses >= so an inverted channel range sweeps only
    // the start channel.
    assign next_dac     = {1'b0, dac} + {1'b0, step};
    assign dac_past_end = next_dac > {1'b0, end_dac};
    assign last_point   = dac_past_end && (chn >= end_chn);
    assign stop_req     = stop_flag | Sweep_Stop;
    assign ocd_rise     = One_Channel_Done & ~ocd_q;
    assign settle_load  = (state == ST_WAIT_CFG) && Config_Done;

    scurve_settle_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_settle_timer (
        .Clk        (Clk),
        .reset      (reset),
        .load       (settle_load),
        .load_value (SETTLE_LOAD),
        .zero       (settle_zero)
    );

    // Next-state logic. The tester's done is edge detected so a level left
    // high from the previous point cannot advance the sweep twice.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (Sweep_Start) state_next = ST_LOAD_CFG;
            ST_LOAD_CFG:  state_next = ST_WAIT_CFG;
            ST_WAIT_CFG:  if (Config_Done) state_next = ST_SETTLE;
            ST_SETTLE:    if (settle_zero) state_next = ST_HEADER;
            ST_HEADER:    state_next = ST_TEST;
            ST_TEST:      state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (ocd_rise) state_next = ST_NEXT;
            ST_NEXT:      state_next = (stop_req || last_point) ? ST_TRAILER : ST_LOAD_CFG;
            ST_TRAILER:   state_next = ST_DONE;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // State register plus the sweep datapath. Ranges are captured on an
    // accepted start so the host may change its inputs during the sweep.
    // The FIFO port is registered: header and trailer are prepared on the
    // edge that enters their state, and tester words are forwarded with one
    // cycle of latency only while waiting on the tester, so the three
    // sources can never collide.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            chn        <= '0;
            dac        <= '0;
            end_chn    <= '0;
            start_dac  <= '0;
            end_dac    <= '0;
            step       <= '0;
            stop_flag  <= 1'b0;
            ocd_q      <= 1'b0;
            fifo_data  <= '0;
            fifo_wr_en <= 1'b0;
        end else begin
            state      <= state_next;
            ocd_q      <= One_Channel_Done;
            fifo_wr_en <= 1'b0;

            if (state == ST_IDLE) begin
                if (Sweep_Start) begin
                    chn       <= Start_Chn;
                    dac       <= Start_DAC;
                    end_chn   <= End_Chn;
                    start_dac <= Start_DAC;
                    end_dac   <= End_DAC;
                    step      <= (DAC_Step == '0) ? DAC_WIDTH'(1) : DAC_Step;
                    stop_flag <= 1'b0;
                end
            end else if (Sweep_Stop) begin
                stop_flag <= 1'b1;
            end

            if ((state == ST_NEXT) && (state_next == ST_LOAD_CFG)) begin
                if (dac_past_end) begin
                    dac <= start_dac;
                    chn <= chn + CHN_WIDTH'(1);
                end else begin
                    dac <= next_dac[DAC_WIDTH-1:0];
                end
            end

            if (state_next == ST_HEADER) begin
                fifo_wr_en <= 1'b1;
                fifo_data  <= {chn, dac};
            end else if (state_next == ST_TRAILER) begin
                fifo_wr_en <= 1'b1;
                fifo_data  <= TRAILER_WORD;
            end else if ((state == ST_WAIT_DONE) && SCurve_Data_wr_en) begin
                fifo_wr_en <= 1'b1;
                fifo_data  <= SCurve_Data;
            end
        end
    end

    // Moore outputs decoded from the state; the point registers feed the
    // slow-control bus directly and only change between points.
    assign Cfg_Chn           = chn;
    assign Cfg_DAC           = dac;
    assign Config_Load       = (state == ST_LOAD_CFG);
    assign SCurve_Test_Start = (state == ST_TEST);
    assign Sweep_Busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign Sweep_Done        = (state == ST_DONE);
    assign Fifo_Data         = fifo_data;
    assign Fifo_wr_en        = fifo_wr_en;

endmodule

// File: tb/tb_scurve_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scurve_sweep_ctrl
// Bench for the S-curve sweep sequencer. A responder plays slow control and
// the single-channel tester; a reference model lists the sweep points with
// plain integer loops and builds the FIFO stream the sequencer must produce.
// -----------------------------------------------------------------------------
module tb_scurve_sweep_ctrl;

    localparam int SETTLE    = 4;
    localparam int WORDS     = 6;
    localparam int CFG_DELAY = 3;
    localparam int OCD_HOLD  = 3;
    localparam int TIMEOUT   = 5000;

    logic        Clk = 1'b0;
    logic        reset;
    logic        Sweep_Start;
    logic        Sweep_Stop;
    logic [5:0]  Start_Chn;
    logic [5:0]  End_Chn;
    logic [9:0]  Start_DAC;
    logic [9:0]  End_DAC;
    logic [9:0]  DAC_Step;
    logic [5:0]  Cfg_Chn;
    logic [9:0]  Cfg_DAC;
    logic        Config_Load;
    logic        Config_Done;
    logic        SCurve_Test_Start;
    logic        One_Channel_Done;
    logic [15:0] SCurve_Data;
    logic        SCurve_Data_wr_en;
    logic [15:0] Fifo_Data;
    logic        Fifo_wr_en;
    logic        Sweep_Busy;
    logic        Sweep_Done;

    scurve_sweep_ctrl #(
        .CHN_WIDTH     (6),
        .DAC_WIDTH     (10),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .Clk               (Clk),
        .reset             (reset),
        .Sweep_Start       (Sweep_Start),
        .Sweep_Stop        (Sweep_Stop),
        .Start_Chn         (Start_Chn),
        .End_Chn           (End_Chn),
        .Start_DAC         (Start_DAC),
        .End_DAC           (End_DAC),
        .DAC_Step          (DAC_Step),
        .Cfg_Chn           (Cfg_Chn),
        .Cfg_DAC           (Cfg_DAC),
        .Config_Load       (Config_Load),
        .Config_Done       (Config_Done),
        .SCurve_Test_Start (SCurve_Test_Start),
        .One_Channel_Done  (One_Channel_Done),
        .SCurve_Data       (SCurve_Data),
        .SCurve_Data_wr_en (SCurve_Data_wr_en),
        .Fifo_Data         (Fifo_Data),
        .Fifo_wr_en        (Fifo_wr_en),
        .Sweep_Busy        (Sweep_Busy),
        .Sweep_Done        (Sweep_Done)
    );

    always #5 Clk = ~Clk;

    int cycle = 0;
    always @(posedge Clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    // Responder controls and state
    bit resp_abort   = 1'b0;
    bit stray_strobe = 1'b0;
    bit stop_pending = 1'b0;
    int stop_at_load = 0;
    int cfg_cnt      = 0;
    int data_idx     = -1;
    int ocd_cnt      = 0;
    int point_no     = 0;
    int cur_point    = 0;
    int load_seen    = 0;

    // Timestamps shared by responder, monitor and main sequence
    int start_cycle    = 0;
    int last_cfg_done  = 0;
    int last_hdr       = 0;
    int ocd_rise_cycle = 0;
    bit awaiting_hdr   = 1'b0;
    bit awaiting_load  = 1'b0;

    // Monitor results and model
    bit          check_en   = 1'b0;
    int          load_count = 0;
    int          done_count = 0;
    int          first_load_lat = 0;
    int          exp_points = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_cfg_q[$];
    logic [15:0] captured[$];
    int          hdr_lat_q[$];
    int          test_lat_q[$];
    int          ocd_lat_q[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    function automatic logic [15:0] testerWord(input int p, input int i);
        return 16'hA000 | 16'((p % 64) * 64) | 16'(i % 64);
    endfunction

    function automatic logic [31:0] capAt(input int idx);
        if (idx < captured.size()) return 32'(captured[idx]);
        return 32'hBAD0_0000;
    endfunction

    // Reference model: enumerate sweep points with integer arithmetic (no
    // overflow possible), truncate after max_points for a stopped sweep, and
    // build the expected FIFO stream and slow-control point list.
    task automatic buildModel(input int sc, input int ec, input int sd, input int ed,
                              input int st, input int max_points);
        int s;
        int c;
        int d;
        int n;
        bit fin;
        logic [15:0] hdr;
        s = (st == 0) ? 1 : st;
        c = sc;
        n = 0;
        fin = 1'b0;
        exp_q.delete();
        exp_cfg_q.delete();
        while (!fin) begin
            d = sd;
            do begin
                if (n < max_points) begin
                    hdr = 16'(c * 1024 + d);
                    exp_cfg_q.push_back(hdr);
                    exp_q.push_back(hdr);
                    for (int i = 0; i < WORDS; i++) exp_q.push_back(testerWord(n, i));
                    n++;
                end
                d += s;
            end while (d <= ed && n < max_points);
            if (c >= ec || n >= max_points) fin = 1'b1;
            else c++;
        end
        exp_q.push_back(16'hFFFF);
        exp_points = n;
    endtask

    // Responder: slow control answers each load CFG_DELAY cycles later; the
    // tester emits WORDS data words after each start and then holds its done
    // level for OCD_HOLD cycles. Optional stray strobe and stop injection.
    initial begin
        Config_Done       = 1'b0;
        One_Channel_Done  = 1'b0;
        SCurve_Data       = '0;
        SCurve_Data_wr_en = 1'b0;
        Sweep_Stop        = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            Config_Done       = 1'b0;
            SCurve_Data_wr_en = 1'b0;
            Sweep_Stop        = stop_pending;
            stop_pending      = 1'b0;
            if (resp_abort) begin
                cfg_cnt          = 0;
                data_idx         = -1;
                ocd_cnt          = 0;
                One_Channel_Done = 1'b0;
                Sweep_Stop       = 1'b0;
            end else begin
                if (cfg_cnt > 0) begin
                    cfg_cnt--;
                    if (cfg_cnt == 0) begin
                        Config_Done   = 1'b1;
                        last_cfg_done = cycle;
                        awaiting_hdr  = 1'b1;
                        if (stray_strobe) begin
                            SCurve_Data_wr_en = 1'b1;
                            SCurve_Data       = 16'hDEAD;
                        end
                    end
                end
                if (Config_Load) begin
                    cfg_cnt = CFG_DELAY;
                    load_seen++;
                    if (load_seen == stop_at_load) stop_pending = 1'b1;
                end
                if (data_idx >= 0) begin
                    if (data_idx < WORDS) begin
                        SCurve_Data_wr_en = 1'b1;
                        SCurve_Data       = testerWord(cur_point, data_idx);
                        data_idx++;
                    end else begin
                        data_idx       = -1;
                        ocd_cnt        = OCD_HOLD;
                        ocd_rise_cycle = cycle;
                        awaiting_load  = 1'b1;
                    end
                end
                One_Channel_Done = (ocd_cnt > 0);
                if (ocd_cnt > 0) ocd_cnt--;
                if (SCurve_Test_Start) begin
                    cur_point = point_no;
                    point_no++;
                    data_idx = 0;
                end
            end
        end
    end

    // Compare process: every FIFO write against the model stream, every
    // slow-control load against the model point list, plus latency logging.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge Clk);
            if (check_en) begin
                if (Fifo_wr_en) begin
                    if (awaiting_hdr) begin
                        hdr_lat_q.push_back(cycle - last_cfg_done);
                        awaiting_hdr = 1'b0;
                        last_hdr     = cycle;
                    end
                    if (exp_q.size() == 0) begin
                        checkOutput("fifo_extra_write", 32'(Fifo_Data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("fifo_word", 32'(Fifo_Data), 32'(e));
                    end
                    captured.push_back(Fifo_Data);
                end
                if (SCurve_Test_Start) test_lat_q.push_back(cycle - last_hdr);
                if (Config_Load) begin
                    load_count++;
                    if (load_count == 1) first_load_lat = cycle - start_cycle;
                    if (awaiting_load) begin
                        ocd_lat_q.push_back(cycle - ocd_rise_cycle);
                        awaiting_load = 1'b0;
                    end
                    checkOutput("busy_at_load", 32'(Sweep_Busy), 32'd1);
                    if (exp_cfg_q.size() == 0) begin
                        checkOutput("cfg_extra_load", 32'd1, 32'd0);
                    end else begin
                        e = exp_cfg_q.pop_front();
                        checkOutput("cfg_point", 32'({Cfg_Chn, Cfg_DAC}), 32'(e));
                    end
                end
                if (Sweep_Done) done_count++;
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cfg_load"},  32'(Config_Load), 0);
        checkOutput({tag, "_cfg_chn"},   32'(Cfg_Chn), 0);
        checkOutput({tag, "_cfg_dac"},   32'(Cfg_DAC), 0);
        checkOutput({tag, "_test_start"},32'(SCurve_Test_Start), 0);
        checkOutput({tag, "_fifo_wr"},   32'(Fifo_wr_en), 0);
        checkOutput({tag, "_fifo_data"}, 32'(Fifo_Data), 0);
        checkOutput({tag, "_busy"},      32'(Sweep_Busy), 0);
        checkOutput({tag, "_done"},      32'(Sweep_Done), 0);
    endtask

    // One full sweep: build model, pulse start, scramble the range inputs,
    // optionally pulse a start while busy, wait (bounded) for done, then
    // check stream completion, counts and latencies.
    task automatic applyStimulus(input int sc, input int ec, input int sd, input int ed,
                                 input int st, input int max_points, input int stop_at,
                                 input int busy_start_delay, input bit stray);
        int k;
        buildModel(sc, ec, sd, ed, st, max_points);
        captured.delete();
        hdr_lat_q.delete();
        test_lat_q.delete();
        ocd_lat_q.delete();
        load_count    = 0;
        done_count    = 0;
        point_no      = 0;
        load_seen     = 0;
        awaiting_hdr  = 1'b0;
        awaiting_load = 1'b0;
        stop_at_load  = stop_at;
        stray_strobe  = stray;
        check_en      = 1'b1;
        @(posedge Clk);
        #1;
        Start_Chn   = 6'(sc);
        End_Chn     = 6'(ec);
        Start_DAC   = 10'(sd);
        End_DAC     = 10'(ed);
        DAC_Step    = 10'(st);
        Sweep_Start = 1'b1;
        start_cycle = cycle;
        @(posedge Clk);
        #1;
        Sweep_Start = 1'b0;
        Start_Chn   = 6'd9;
        End_Chn     = 6'd40;
        Start_DAC   = 10'd333;
        End_DAC     = 10'd900;
        DAC_Step    = 10'd7;
        k = 0;
        while (done_count == 0 && k < TIMEOUT) begin
            @(posedge Clk);
            #1;
            Sweep_Start = (busy_start_delay > 0) && (k == busy_start_delay);
            k++;
        end
        Sweep_Start = 1'b0;
        if (done_count == 0) checkOutput("sweep_timeout", 32'd0, 32'd1);
        repeat (4) @(posedge Clk);
        #1;
        checkOutput("stream_left", 32'(exp_q.size()), 0);
        checkOutput("points_left", 32'(exp_cfg_q.size()), 0);
        checkOutput("done_pulses", 32'(done_count), 1);
        checkOutput("load_pulses", 32'(load_count), 32'(exp_points));
        checkOutput("busy_after", 32'(Sweep_Busy), 0);
        checkOutput("start_to_load", 32'(first_load_lat), 1);
        checkOutput("hdr_count", 32'(hdr_lat_q.size()), 32'(exp_points));
        foreach (hdr_lat_q[i]) checkOutput("settle_latency", 32'(hdr_lat_q[i]), SETTLE + 1);
        foreach (test_lat_q[i]) checkOutput("hdr_to_test", 32'(test_lat_q[i]), 1);
        foreach (ocd_lat_q[i]) checkOutput("ocd_to_load", 32'(ocd_lat_q[i]), 2);
        check_en     = 1'b0;
        stop_at_load = 0;
        stray_strobe = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        reset       = 1'b1;
        Sweep_Start = 1'b0;
        Start_Chn   = '0;
        End_Chn     = '0;
        Start_DAC   = '0;
        End_DAC     = '0;
        DAC_Step    = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkAllZero("reset");
        @(posedge Clk);
        #1;
        reset = 1'b0;

        $display("[TB] single point");
        applyStimulus(5, 5, 100, 100, 1, 99, 0, 0, 1'b0);
        checkOutput("single_hdr", capAt(0), 32'h1464);
        checkOutput("single_w0", capAt(1), 32'hA000);
        checkOutput("single_w5", capAt(6), 32'hA005);
        checkOutput("single_trailer", capAt(7), 32'hFFFF);
        checkOutput("single_len", 32'(captured.size()), 8);

        $display("[TB] DAC wrap with start while busy");
        applyStimulus(0, 1, 1020, 1023, 2, 99, 0, 20, 1'b0);
        checkOutput("wrap_hdr0", capAt(0), 32'h03FC);
        checkOutput("wrap_hdr1", capAt(7), 32'h03FE);
        checkOutput("wrap_hdr2", capAt(14), 32'h07FC);
        checkOutput("wrap_hdr3", capAt(21), 32'h07FE);
        checkOutput("wrap_p3w0", capAt(22), 32'hA0C0);
        checkOutput("wrap_trailer", capAt(28), 32'hFFFF);
        checkOutput("wrap_loads", 32'(load_count), 4);

        $display("[TB] step zero with stray tester strobe");
        applyStimulus(3, 3, 0, 2, 0, 99, 0, 0, 1'b1);
        checkOutput("step0_hdr0", capAt(0), 32'h0C00);
        checkOutput("step0_hdr1", capAt(7), 32'h0C01);
        checkOutput("step0_hdr2", capAt(14), 32'h0C02);
        checkOutput("step0_trailer", capAt(21), 32'hFFFF);
        checkOutput("step0_loads", 32'(load_count), 3);

        $display("[TB] inverted ranges");
        applyStimulus(10, 8, 50, 20, 1, 99, 0, 0, 1'b0);
        checkOutput("degen_hdr", capAt(0), 32'h2832);
        checkOutput("degen_trailer", capAt(7), 32'hFFFF);
        checkOutput("degen_len", 32'(captured.size()), 8);

        $display("[TB] stop during second load");
        applyStimulus(0, 2, 0, 3, 1, 2, 2, 0, 1'b0);
        checkOutput("stop_hdr0", capAt(0), 32'h0000);
        checkOutput("stop_hdr1", capAt(7), 32'h0001);
        checkOutput("stop_trailer", capAt(14), 32'hFFFF);
        checkOutput("stop_len", 32'(captured.size()), 15);
        checkOutput("stop_loads", 32'(load_count), 2);

        $display("[TB] reset mid sweep");
        point_no  = 0;
        load_seen = 0;
        @(posedge Clk);
        #1;
        Start_Chn   = 6'd2;
        End_Chn     = 6'd3;
        Start_DAC   = 10'd7;
        End_DAC     = 10'd9;
        DAC_Step    = 10'd1;
        Sweep_Start = 1'b1;
        @(posedge Clk);
        #1;
        Sweep_Start = 1'b0;
        k = 0;
        while (!SCurve_Test_Start && k < TIMEOUT) begin
            @(posedge Clk);
            #1;
            k++;
        end
        checkOutput("reach_test", 32'(SCurve_Test_Start), 1);
        repeat (3) @(posedge Clk);
        #1;
        reset      = 1'b1;
        resp_abort = 1'b1;
        @(posedge Clk);
        #1;
        checkAllZero("midreset");
        reset = 1'b0;
        @(posedge Clk);
        #1;
        resp_abort = 1'b0;
        repeat (2) @(posedge Clk);
        applyStimulus(2, 2, 7, 8, 1, 99, 0, 0, 1'b0);
        checkOutput("restart_hdr0", capAt(0), 32'h0807);
        checkOutput("restart_hdr1", capAt(7), 32'h0808);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
